// File: rtl/dw_pulse_sync_pkg.sv
// Shared constants for the toggle-encoded pulse crossing (sender and receiver).
package dw_pulse_sync_pkg;

    // ack_d behaviour selectors.
    localparam int ACK_ON_DETECT  = 0;
    localparam int ACK_ON_CONSUME = 1;

    // Legal parameter ranges for the crossing.
    localparam int F_SYNC_MAX    = 4;
    localparam int CNT_WIDTH_MAX = 8;

    // Warm-up counter must hold f_sync_type+1, i.e. up to F_SYNC_MAX+1.
    localparam int WARM_W = 3;

endpackage

// File: rtl/dw_sync_chain.sv
// N-flop level synchroniser with synchronous active-high clear; depth 0 is a wire.
module dw_sync_chain #(
    parameter int depth = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    if (depth == 0) begin : g_wire
        assign q = d;
    end else begin : g_flops
        logic [depth-1:0] sync_q;
        logic [depth-1:0] sync_d;

        // Shift the incoming level one stage deeper each cycle.
        always_comb begin
            sync_d    = sync_q << 1;
            sync_d[0] = d;
        end

        // Chain registers; clear returns every stage to 0.
        always_ff @(posedge clk) begin
            if (clr) begin
                sync_q <= '0;
            end else begin
                sync_q <= sync_d;
            end
        end

        assign q = sync_q[depth-1];
    end

endmodule

// File: rtl/dw_pulse_recv_ack.sv
// Destination-side receiver of a toggle-encoded pulse crossing. Each level
// change of toggle_s becomes one event, buffered in a saturating counter and
// offered on a valid/ready interface; ack_d toggles back to pace the source.
//
// Handshake: event_d is valid, event_rdy_d is ready. An event is consumed on
// every rising clk_d edge where event_d & event_rdy_d; event_d never drops
// while a pending event is unconsumed.
module dw_pulse_recv_ack
    import dw_pulse_sync_pkg::*;
#(
    parameter int f_sync_type = 2,
    parameter int reg_event   = 1,
    parameter int cnt_width   = 2,
    parameter int ack_mode    = 0
) (
    input  logic                 clk_d,
    input  logic                 rst_d,
    input  logic                 toggle_s,
    input  logic                 event_rdy_d,
    output logic                 event_d,
    output logic                 ack_d,
    output logic [cnt_width-1:0] pending_d,
    output logic                 busy_d,
    output logic                 ovfl_d
);

    localparam logic [cnt_width-1:0] PEND_MAX  = '1;
    localparam logic [cnt_width-1:0] PEND_ONE  = cnt_width'(1);
    localparam logic [WARM_W-1:0]    WARM_INIT = WARM_W'(f_sync_type + 1);

    logic                 tog_sync;
    logic                 tog_prev_q, tog_prev_d;
    logic [WARM_W-1:0]    warm_q, warm_d;
    logic [cnt_width-1:0] pend_q, pend_d;
    logic                 ack_tog_q, ack_tog_d;
    logic                 ovfl_flag_q, ovfl_flag_d;

    logic warm_active;
    logic pend_nz;
    logic det;
    logic consume;
    logic event_valid;

    dw_sync_chain #(
        .depth (f_sync_type)
    ) u_sync (
        .clk (clk_d),
        .clr (rst_d),
        .d   (toggle_s),
        .q   (tog_sync)
    );

    // While warming up, tog_prev tracks the settling chain so a toggle_s
    // that was already high at reset release is not seen as an event.
    assign warm_active = (warm_q != '0);
    assign pend_nz     = (pend_q != '0);
    assign det         = (tog_sync ^ tog_prev_q) & ~warm_active;

    // Registered mode serves only buffered events; bypass mode also offers
    // the event in its detect cycle, so it can be taken without buffering.
    assign event_valid = (reg_event != 0) ? pend_nz : (det | pend_nz);
    assign consume     = event_valid & event_rdy_d;

    // Next-state: warm-up countdown, edge history, saturating count, ack.
    always_comb begin
        warm_d      = warm_q;
        tog_prev_d  = tog_sync;
        pend_d      = pend_q;
        ovfl_flag_d = ovfl_flag_q;
        ack_tog_d   = ack_tog_q;

        if (warm_active) begin
            warm_d = warm_q - WARM_W'(1);
        end

        // Simultaneous detect and consume cancel out.
        if (det && !consume) begin
            if (pend_q == PEND_MAX) begin
                ovfl_flag_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_ONE;
            end
        end else if (consume && !det) begin
            pend_d = pend_q - PEND_ONE;
        end

        if (ack_mode == ACK_ON_CONSUME) begin
            ack_tog_d = ack_tog_q ^ consume;
        end else begin
            ack_tog_d = ack_tog_q ^ det;
        end
    end

    // State registers; reset drops pending events without acknowledging them.
    always_ff @(posedge clk_d) begin
        if (rst_d) begin
            warm_q      <= WARM_INIT;
            tog_prev_q  <= 1'b0;
            pend_q      <= '0;
            ovfl_flag_q <= 1'b0;
            ack_tog_q   <= 1'b0;
        end else begin
            warm_q      <= warm_d;
            tog_prev_q  <= tog_prev_d;
            pend_q      <= pend_d;
            ovfl_flag_q <= ovfl_flag_d;
            ack_tog_q   <= ack_tog_d;
        end
    end

    assign event_d   = event_valid;
    assign ack_d     = ack_tog_q;
    assign pending_d = pend_q;
    assign busy_d    = pend_nz | warm_active;
    assign ovfl_d    = ovfl_flag_q;

endmodule

// File: tb/tb_dw_pulse_recv_ack.sv
// Directed bench: instance a is registered/ack-on-detect, instance b is
// bypass/ack-on-consume; both use a 2-flop sync and a 2-bit counter.
module tb_dw_pulse_recv_ack;

    logic       clk;
    logic       rst;
    logic       tog_a, rdy_a, tog_b, rdy_b;
    logic       ev_a, ack_a, busy_a, ovfl_a;
    logic       ev_b, ack_b, busy_b, ovfl_b;
    logic [1:0] pend_a, pend_b;

    int checks = 0;
    int errors = 0;
    logic exp_ack_a = 1'b0;
    logic exp_ack_b = 1'b0;

    dw_pulse_recv_ack #(
        .f_sync_type (2),
        .reg_event   (1),
        .cnt_width   (2),
        .ack_mode    (0)
    ) dut_a (
        .clk_d       (clk),
        .rst_d       (rst),
        .toggle_s    (tog_a),
        .event_rdy_d (rdy_a),
        .event_d     (ev_a),
        .ack_d       (ack_a),
        .pending_d   (pend_a),
        .busy_d      (busy_a),
        .ovfl_d      (ovfl_a)
    );

    dw_pulse_recv_ack #(
        .f_sync_type (2),
        .reg_event   (0),
        .cnt_width   (2),
        .ack_mode    (1)
    ) dut_b (
        .clk_d       (clk),
        .rst_d       (rst),
        .toggle_s    (tog_b),
        .event_rdy_d (rdy_b),
        .event_d     (ev_b),
        .ack_d       (ack_b),
        .pending_d   (pend_b),
        .busy_d      (busy_b),
        .ovfl_d      (ovfl_b)
    );

    // Clock and run-time bound.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    // Advance one rising edge; return on the falling edge for drive/sample.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One event on instance a with rdy_a=1: event_d high for exactly the
    // cycle after edge k+2, ack toggles at edge k+2.
    task automatic event_a_timing(input string tag);
        tog_a = ~tog_a;
        tick();  // edge k
        check({tag, "_ev_k"}, {7'd0, ev_a}, 8'd0);
        tick();  // edge k+1, det high now
        check({tag, "_ev_k1"}, {7'd0, ev_a}, 8'd0);
        check({tag, "_ack_k1"}, {7'd0, ack_a}, {7'd0, exp_ack_a});
        tick();  // edge k+2
        exp_ack_a = ~exp_ack_a;
        check({tag, "_ev_k2"}, {7'd0, ev_a}, 8'd1);
        check({tag, "_pend_k2"}, {6'd0, pend_a}, 8'd1);
        check({tag, "_ack_k2"}, {7'd0, ack_a}, {7'd0, exp_ack_a});
        tick();  // edge k+3, consumed
        check({tag, "_ev_k3"}, {7'd0, ev_a}, 8'd0);
        check({tag, "_pend_k3"}, {6'd0, pend_a}, 8'd0);
    endtask

    initial begin
        rst   = 1'b1;
        tog_a = 1'b1;
        tog_b = 1'b0;
        rdy_a = 1'b0;
        rdy_b = 1'b0;
        @(negedge clk);
        tick();
        tick();

        // Reset state, toggle_s high through reset.
        check("rst_ev_a", {7'd0, ev_a}, 8'd0);
        check("rst_ack_a", {7'd0, ack_a}, 8'd0);
        check("rst_pend_a", {6'd0, pend_a}, 8'd0);
        check("rst_ovfl_a", {7'd0, ovfl_a}, 8'd0);
        check("rst_busy_a", {7'd0, busy_a}, 8'd1);
        check("rst_busy_b", {7'd0, busy_b}, 8'd1);

        // Warm-up lasts three edges after release.
        rst = 1'b0;
        tick();
        check("wu1_busy", {7'd0, busy_a}, 8'd1);
        tick();
        check("wu2_busy", {7'd0, busy_a}, 8'd1);
        tick();
        check("wu3_busy", {7'd0, busy_a}, 8'd0);
        for (int i = 0; i < 4; i++) begin
            check("wu_no_ev", {7'd0, ev_a}, 8'd0);
            check("wu_no_pend", {6'd0, pend_a}, 8'd0);
            check("wu_no_ack", {7'd0, ack_a}, 8'd0);
            tick();
        end

        // Single events with consumer ready, both edge directions.
        rdy_a = 1'b1;
        event_a_timing("ev10");
        event_a_timing("ev01");

        // Saturation: five events with consumer stalled.
        rdy_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tog_a = ~tog_a;
            repeat (4) tick();
            exp_ack_a = ~exp_ack_a;
            check("sat_pend", {6'd0, pend_a}, (i < 3) ? 8'(i + 1) : 8'd3);
            check("sat_ovfl", {7'd0, ovfl_a}, (i >= 3) ? 8'd1 : 8'd0);
            check("sat_ack", {7'd0, ack_a}, {7'd0, exp_ack_a});
        end
        check("sat_ev", {7'd0, ev_a}, 8'd1);
        check("sat_busy", {7'd0, busy_a}, 8'd1);

        // Drain three buffered events.
        rdy_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("drain_pend", {6'd0, pend_a}, 8'(2 - i));
        end
        check("drain_ev", {7'd0, ev_a}, 8'd0);
        check("drain_ovfl_sticky", {7'd0, ovfl_a}, 8'd1);
        check("drain_ack", {7'd0, ack_a}, {7'd0, exp_ack_a});
        rdy_a = 1'b0;

        // Bypass: event offered in its detect cycle, taken without buffering.
        rdy_b = 1'b1;
        tog_b = ~tog_b;
        tick();
        check("byp_ev_k", {7'd0, ev_b}, 8'd0);
        tick();
        check("byp_ev_det", {7'd0, ev_b}, 8'd1);
        check("byp_pend_det", {6'd0, pend_b}, 8'd0);
        check("byp_ack_det", {7'd0, ack_b}, 8'd0);
        tick();
        exp_ack_b = 1'b1;
        check("byp_ev_after", {7'd0, ev_b}, 8'd0);
        check("byp_pend_after", {6'd0, pend_b}, 8'd0);
        check("byp_ack_after", {7'd0, ack_b}, {7'd0, exp_ack_b});

        // Build pending_b = 2 with consumer stalled; no consume-ack.
        rdy_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tog_b = ~tog_b;
            repeat (4) tick();
            check("b_fill_pend", {6'd0, pend_b}, 8'(i + 1));
            check("b_fill_ack", {7'd0, ack_b}, {7'd0, exp_ack_b});
        end

        // Detect and consume in the same cycle: count holds, ack toggles once.
        tog_b = ~tog_b;
        tick();
        tick();
        rdy_b = 1'b1;
        check("both_ev", {7'd0, ev_b}, 8'd1);
        tick();
        rdy_b = 1'b0;
        exp_ack_b = ~exp_ack_b;
        check("both_pend", {6'd0, pend_b}, 8'd2);
        check("both_ack", {7'd0, ack_b}, {7'd0, exp_ack_b});
        tick();
        check("both_pend_hold", {6'd0, pend_b}, 8'd2);
        check("both_ack_hold", {7'd0, ack_b}, {7'd0, exp_ack_b});

        // Drain instance b; each consume toggles ack.
        rdy_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_ack_b = ~exp_ack_b;
            check("b_drain_pend", {6'd0, pend_b}, 8'(1 - i));
            check("b_drain_ack", {7'd0, ack_b}, {7'd0, exp_ack_b});
        end
        tick();
        check("b_drain_ev", {7'd0, ev_b}, 8'd0);
        check("b_ovfl", {7'd0, ovfl_b}, 8'd0);
        rdy_b = 1'b0;

        // Reset mid-operation with pending_a full and overflow set.
        for (int i = 0; i < 3; i++) begin
            tog_a = ~tog_a;
            repeat (4) tick();
        end
        check("pre_rst_pend", {6'd0, pend_a}, 8'd3);
        check("pre_rst_ovfl", {7'd0, ovfl_a}, 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_pend", {6'd0, pend_a}, 8'd0);
        check("mid_rst_ovfl", {7'd0, ovfl_a}, 8'd0);
        check("mid_rst_ack", {7'd0, ack_a}, 8'd0);
        check("mid_rst_ev", {7'd0, ev_a}, 8'd0);
        check("mid_rst_busy", {7'd0, busy_a}, 8'd1);
        check("mid_rst_ack_b", {7'd0, ack_b}, 8'd0);
        repeat (3) tick();
        check("post_rst_busy", {7'd0, busy_a}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            check("post_rst_ev", {7'd0, ev_a}, 8'd0);
            check("post_rst_ack", {7'd0, ack_a}, 8'd0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
